// File: rtl/control_fd_pkg.sv
// Shared decode constants, forward-select encoding and history entry type
// for the fetch/decode control block.
package control_fd_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,  // register file (includes write-through)
        FWD_M    = 2'b01,  // producer one ahead, ALU result in M
        FWD_WB   = 2'b10,  // producer two ahead, WB data
        FWD_RSVD = 2'b11   // never driven
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwen;
        logic       is_load;
    } hist_entry_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI) ||
               (op == OP_AUIPC);
    endfunction

endpackage

// File: rtl/fd_scoreboard.sv
// Two-entry issue history (X slot, M slot) with source-register match logic.
module fd_scoreboard
    import control_fd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        insert_i,
    input  hist_entry_t entry_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output fwd_sel_e    rs1_sel_o,
    output fwd_sel_e    rs2_sel_o,
    output logic        rs1_load_hit_o,
    output logic        rs2_load_hit_o
);

    hist_entry_t x_q;
    hist_entry_t m_q;

    function automatic logic hit(input hist_entry_t e, input logic [4:0] rs);
        return e.valid && e.regwen && (e.rd == rs) && (rs != 5'd0);
    endfunction

    function automatic fwd_sel_e pick(input hist_entry_t x, input hist_entry_t m,
                                      input logic [4:0] rs);
        if (hit(x, rs))      return FWD_M;
        else if (hit(m, rs)) return FWD_WB;
        else                 return FWD_RF;
    endfunction

    // Age history one slot per cycle; a bubble or dead D slot inserts an invalid entry.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking so m_q captures the old x_q, not the newly inserted entry.
        if (rst_i) begin
            x_q <= '0;
            m_q <= '0;
        end else begin
            m_q <= x_q;
            x_q <= insert_i ? entry_i : '0;
        end
    end

    // Nearest producer wins; only an X-slot load can cause a load-use hazard.
    always_comb begin
        rs1_sel_o      = pick(x_q, m_q, rs1_i);
        rs2_sel_o      = pick(x_q, m_q, rs2_i);
        rs1_load_hit_o = hit(x_q, rs1_i) && x_q.is_load;
        rs2_load_hit_o = hit(x_q, rs2_i) && x_q.is_load;
    end

endmodule

// File: rtl/control_fd.sv
// F->D pipeline register with load-use stall, redirect flush and operand
// forwarding selects for the decode stage.
module control_fd
    import control_fd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_F_i,
    input  logic [31:0] inst_F_i,
    input  logic        valid_F_i,
    input  logic        redirect_X_i,
    output logic [31:0] pc_D_o,
    output logic [31:0] inst_D_o,
    output logic        valid_D_o,
    output logic        stall_F_o,
    output logic        bubble_D_o,
    output logic [3:0]  opforward_D_o,
    output logic [1:0]  opforward_Dstore_o
);

    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use1;
    logic        use2;
    logic        is_store;
    logic        insert;
    hist_entry_t entry;
    fwd_sel_e    rs1_sel;
    fwd_sel_e    rs2_sel;
    fwd_sel_e    sel1;
    fwd_sel_e    sel2;
    logic        rs1_load_hit;
    logic        rs2_load_hit;

    assign op  = inst_D_o[6:0];
    assign rs1 = inst_D_o[19:15];
    assign rs2 = inst_D_o[24:20];
    assign rd  = inst_D_o[11:7];

    fd_scoreboard u_scoreboard (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .insert_i       (insert),
        .entry_i        (entry),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .rs1_sel_o      (rs1_sel),
        .rs2_sel_o      (rs2_sel),
        .rs1_load_hit_o (rs1_load_hit),
        .rs2_load_hit_o (rs2_load_hit)
    );

    // Hazard, bubble and forward-select decode from the D register and history.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        use1               = valid_D_o && uses_rs1(op);
        use2               = valid_D_o && uses_rs2(op);
        is_store           = (op == OP_STORE);
        sel1               = use1 ? rs1_sel : FWD_RF;
        sel2               = use2 ? rs2_sel : FWD_RF;
        stall_F_o          = 1'b0;
        bubble_D_o         = redirect_X_i;
        opforward_D_o      = {is_store ? FWD_RF : sel2, sel1};
        opforward_Dstore_o = is_store ? sel2 : FWD_RF;

        // Redirect kills D, so a load-use hazard under it never holds fetch.
        if (!redirect_X_i && ((use1 && rs1_load_hit) || (use2 && rs2_load_hit))) begin
            stall_F_o  = 1'b1;
            bubble_D_o = 1'b1;
        end

        entry.valid   = valid_D_o;
        entry.rd      = rd;
        entry.regwen  = writes_rd(op) && (rd != 5'd0);
        entry.is_load = (op == OP_LOAD);
        insert        = valid_D_o && !bubble_D_o;
    end

    // D register: reset, flush on redirect, hold on stall, else load fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_D_o    <= 32'd0;
            inst_D_o  <= NOP_INST;
            valid_D_o <= 1'b0;
        end else if (redirect_X_i) begin
            pc_D_o    <= pc_F_i;
            inst_D_o  <= NOP_INST;
            valid_D_o <= 1'b0;
        end else if (!stall_F_o) begin
            pc_D_o    <= pc_F_i;
            inst_D_o  <= valid_F_i ? inst_F_i : NOP_INST;
            valid_D_o <= valid_F_i;
        end
    end

endmodule

// File: doc/control_fd.md
CONTROL_FD -- requirements
Module: control_fd

Interface
REQ-001 SHALL have: clk_i  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_i  in  1  synchronous, active-high reset.
REQ-003 SHALL have: pc_F_i  in  32  PC of fetched instruction.
REQ-004 SHALL have: inst_F_i  in  32  fetched instruction word.
REQ-005 SHALL have: valid_F_i  in  1  fetch word valid.
REQ-006 SHALL have: redirect_X_i  in  1  taken branch/jump resolved in X; kill younger instructions.
REQ-007 SHALL have: pc_D_o  out  32  registered PC to decode and the D->X register.
REQ-008 SHALL have: inst_D_o  out  32  registered instruction.
REQ-009 SHALL have: valid_D_o  out  1  D slot holds a live instruction.
REQ-010 SHALL have: stall_F_o  out  1  hold PC and fetch this cycle.
REQ-011 SHALL have: bubble_D_o  out  1  downstream zeroes othersig into D->X this cycle.
REQ-012 SHALL have: opforward_D_o  out  4  [1:0] rs1 select, [3:2] rs2 ALU-operand select.
REQ-013 SHALL have: opforward_Dstore_o  out  2  store-data select.

Function
REQ-014 Forward select encoding SHALL be: 00 register file, 01 M-stage ALU result (producer 1 ahead), 10 WB data (producer 2 ahead), 11 never driven.
REQ-015 Decode fields SHALL be: rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7], opcode=inst[6:0].
REQ-016 rs1 SHALL count as used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111; rs2 for 0110011, 0100011, 1100011.
REQ-017 rd SHALL count as written for 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111; rd=x0 SHALL never count.
REQ-018 Block SHALL keep a two-entry history (X slot, M slot): {valid, rd, regwen, is_load} of instructions issued from D.
REQ-019 Every cycle M slot SHALL take X slot; X slot SHALL take D's entry when valid_D_o=1 and bubble_D_o=0, else an invalid entry.
REQ-020 Per used source, match against X slot SHALL select 01, else against M slot 10, else 00; nearest match wins.
REQ-021 For stores, opforward_D_o[3:2] SHALL be 00 and rs2 select SHALL appear on opforward_Dstore_o; otherwise opforward_Dstore_o SHALL be 00.
REQ-022 Load-use: valid D with a used source matching a valid X-slot load SHALL assert stall_F_o and bubble_D_o for exactly one cycle while D holds.
REQ-023 On the cycle after a load-use stall, the same source SHALL select 10.
REQ-024 Producers 3+ ahead SHALL select 00; the register file provides write-through.
REQ-025 On redirect_X_i=1: bubble_D_o=1, stall_F_o=0; next cycle valid_D_o=0 and inst_D_o=32'h00000013 irrespective of fetch.
REQ-026 Redirect SHALL take priority over load-use stall in the same cycle.
REQ-027 With no stall or redirect, D SHALL load {pc_F_i, inst_F_i, valid_F_i}; valid_F_i=0 loads inst 32'h00000013, valid 0.
REQ-028 Invalid D SHALL drive opforward outputs 00 and never stall.
REQ-029 opforward/stall/bubble outputs SHALL be combinational from D register and history; latency F->D one cycle.

Reset
REQ-030 While rst_i=1 at a clock edge: pc_D_o=0, inst_D_o=32'h00000013, valid_D_o=0, both history entries invalid.
REQ-031 Consequently stall_F_o, bubble_D_o, opforward_D_o, opforward_Dstore_o SHALL be 0 the cycle after reset; reset mid-stall SHALL discard the held instruction.

Structure
REQ-032 Shared package SHALL hold opcode constants, fwd_sel_e enum (4 values), hist_entry_t struct, NOP constant.
REQ-033 History SHALL be a sub-module fd_scoreboard (shift, flush-insert, match ports).

Verification
REQ-034 add x5,x1,x2 then add x6,x5,x3 back-to-back -> second in D gives opforward_D_o[1:0]=01, no stall.
REQ-035 lw x5,0(x1) then add x6,x5,x5 -> stall_F_o=1, bubble_D_o=1 one cycle; next cycle opforward_D_o=4'b1010.
REQ-036 add x7,.. ; nop ; sw x7,4(x2) -> opforward_Dstore_o=10, opforward_D_o[3:2]=00.
REQ-037 redirect_X_i=1 together with load-use hazard -> stall_F_o=0, bubble_D_o=1, next valid_D_o=0, inst_D_o=32'h00000013.
REQ-038 add x0,x1,x2 then add x3,x0,x0 -> opforward_D_o=0000.
REQ-039 rst_i=1 during stall cycle -> next cycle all outputs per REQ-030/031.
